msi_snoop_responder: RTL
========================

# msi_snoop_responder

Bus-side MSI coherence responder for the 2-way L1 cache. Accepts one snoop request at a time from the shared bus, looks up both ways' tag and MSI state RAMs for the snooped set, computes the snoop-induced MSI transition, writes the new state back into the hitting way's state field, and returns a hit/flush response to the bus. It is the consumer and updater of the per-way tag/MSI-state storage.

## Interface
Parameters:
- ADDR_W, 16, snoop address width
- INDEX_W, 3, set index width; index = addr[4:2]
- TAG_W, 11, tag width; tag = addr[15:5]

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- snp_valid  in  1  snoop request valid
- snp_ready  out  1  responder can accept a snoop
- snp_cmd  in  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 reserved
- snp_addr  in  ADDR_W  snooped address
- tag_rd_en  out  1  tag/state RAM read strobe, both ways
- tag_rd_index  out  INDEX_W  set to read
- w0_tag_in, w1_tag_in  in  TAG_W  way tags, valid the cycle after tag_rd_en
- w0_state_in, w1_state_in  in  2  way MSI states, same timing
- st_wr_en  out  1  MSI state write strobe
- st_wr_way  out  1  way written (0/1)
- st_wr_index  out  INDEX_W  set written
- st_wr_state  out  2  new MSI state
- rsp_valid  out  1  response valid
- rsp_ready  in  1  bus accepts response
- rsp_hit  out  1  snoop hit a valid line
- rsp_flush  out  1  line was M; data must be flushed
- rsp_way  out  1  way that hit (0 when no hit)

## Operation
- MSI encoding: I=00, S=01, M=10; 11 treated as I.
- FSM states: IDLE, LOOKUP, DECIDE, RESP.
- IDLE: snp_ready=1. On snp_valid&&snp_ready, latch snp_cmd and snp_addr -> LOOKUP.
- LOOKUP: tag_rd_en=1, tag_rd_index=latched index -> DECIDE.
- DECIDE: hitN = (wN_tag_in==latched tag) && wN_state_in!=I. Way 0 wins if both hit. Register hit, way, old state, next state, flush -> RESP.
- Transitions, applied to the hitting way's state:
  - BusRd: M->S flush=1; S->S flush=0.
  - BusRdX: M->I flush=1; S->I flush=0.
  - BusUpgr: S->I flush=0; M->I flush=1 (protocol anomaly; line still flushed).
  - reserved cmd, or miss: hit=0, flush=0, no write.
- RESP: st_wr_en=1 on first RESP cycle only, and only if hit and next state != old state. rsp_valid held with stable rsp_* until rsp_ready; on handshake -> IDLE.
- rsp_* outputs are 0 whenever rsp_valid=0.

## Timing
- Reset (async assert, sync release): FSM=IDLE; snp_ready=1 after release, 0 while reset_n=0; tag_rd_en, st_wr_en, rsp_valid, rsp_hit, rsp_flush, rsp_way=0; index/state outputs=0.
- Accept at edge T -> tag_rd_en in cycle T+1 -> RAM data sampled at edge T+2 -> rsp_valid and st_wr_en asserted from T+2, i.e. rsp_valid 2 cycles after acceptance.
- rsp_ready already high: handshake in first RESP cycle, snp_ready high next cycle; peak throughput 1 snoop / 4 cycles.
- rsp_ready low: stay in RESP, no second state write, snp_ready=0.
- snp_valid ignored outside IDLE; no request queuing.
- Reset mid-operation: pending snoop dropped, no state write, no response issued.
- Read and write never overlap: write happens only in RESP, after the read has completed.

## Structure
- Package msi_pkg: MSI state localparams (I/S/M), snoop cmd localparams, INDEX_W/TAG_W defaults, FSM state encoding.
- Sub-module msi_snoop_decode: combinational (cmd, old state) -> (next state, flush, write-needed); instantiated once, fed by the selected hitting way.

## Test plan
- Way 1 in M with matching tag, BusRd to addr 0x1234 (index 5) -> rsp_hit=1, rsp_flush=1, rsp_way=1; one st_wr_en pulse with way=1, index=5, state=S.
- Way 0 in S, BusRdX -> hit=1, flush=0, way=0; single write of I. Repeat with BusUpgr -> identical result.
- Tag mismatch in both ways, or matching way in I -> hit=0, flush=0, no st_wr_en; rsp_valid still asserted at T+2.
- Both ways matching in S -> way 0 reported and written, way 1 untouched.
- rsp_ready held low 5 cycles -> rsp_* stable, st_wr_en pulses exactly once, snp_ready low until the cycle after the handshake.
- reset_n pulsed low during LOOKUP -> all outputs 0 immediately; after release, IDLE with snp_ready=1; no write or response occurs for the dropped snoop.

Source files
------------

// File: rtl/msi_pkg.sv
// Shared definitions for the MSI snoop responder: state/command encodings,
// default geometry and the responder FSM encoding.
package msi_pkg;

    localparam int INDEX_W_DEF = 3;
    localparam int TAG_W_DEF   = 11;

    localparam logic [1:0] MSI_I = 2'b00;
    localparam logic [1:0] MSI_S = 2'b01;
    localparam logic [1:0] MSI_M = 2'b10;

    localparam logic [1:0] CMD_BUSRD   = 2'b00;
    localparam logic [1:0] CMD_BUSRDX  = 2'b01;
    localparam logic [1:0] CMD_BUSUPGR = 2'b10;
    localparam logic [1:0] CMD_RSVD    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOOKUP = 2'b01,
        ST_DECIDE = 2'b10,
        ST_RESP   = 2'b11
    } fsm_state_e;

    // Encoding 11 is treated as invalid alongside I.
    function automatic logic msi_is_valid(input logic [1:0] st);
        return (st == MSI_S) || (st == MSI_M);
    endfunction

endpackage

// File: rtl/msi_snoop_decode.sv
// Combinational snoop transition: (bus command, current line state) ->
// (next line state, flush required, state write required).
module msi_snoop_decode
    import msi_pkg::*;
(
    input  logic [1:0] cmd,
    input  logic [1:0] old_state,
    output logic [1:0] next_state,
    output logic       flush,
    output logic       wr_needed
);

    // Next-state and flush selection per snoop command.
    always_comb begin
        next_state = old_state;
        flush      = 1'b0;
        case (cmd)
            CMD_BUSRD: begin
                if (old_state == MSI_M) begin
                    next_state = MSI_S;
                    flush      = 1'b1;
                end else begin
                    next_state = old_state;
                    flush      = 1'b0;
                end
            end
            // BusUpgr against an M line is anomalous but the dirty data is still pushed out.
            CMD_BUSRDX, CMD_BUSUPGR: begin
                next_state = MSI_I;
                flush      = (old_state == MSI_M);
            end
            default: begin
                next_state = old_state;
                flush      = 1'b0;
            end
        endcase
        wr_needed = msi_is_valid(old_state) && (next_state != old_state);
    end

endmodule

// File: rtl/msi_snoop_responder.sv
// Bus-side MSI snoop responder for a 2-way L1: reads both ways' tag/state for
// the snooped set, applies the snoop transition to the hitting way and responds.
module msi_snoop_responder
    import msi_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               snp_valid,
    output logic               snp_ready,
    input  logic [1:0]         snp_cmd,
    input  logic [ADDR_W-1:0]  snp_addr,
    output logic               tag_rd_en,
    output logic [INDEX_W-1:0] tag_rd_index,
    input  logic [TAG_W-1:0]   w0_tag_in,
    input  logic [TAG_W-1:0]   w1_tag_in,
    input  logic [1:0]         w0_state_in,
    input  logic [1:0]         w1_state_in,
    output logic               st_wr_en,
    output logic               st_wr_way,
    output logic [INDEX_W-1:0] st_wr_index,
    output logic [1:0]         st_wr_state,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_hit,
    output logic               rsp_flush,
    output logic               rsp_way
);

    fsm_state_e         state_q, state_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic               snp_ready_q, snp_ready_d;
    logic               tag_rd_en_q, tag_rd_en_d;
    logic [INDEX_W-1:0] tag_rd_index_q, tag_rd_index_d;
    logic               st_wr_en_q, st_wr_en_d;
    logic               st_wr_way_q, st_wr_way_d;
    logic [INDEX_W-1:0] st_wr_index_q, st_wr_index_d;
    logic [1:0]         st_wr_state_q, st_wr_state_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic               rsp_flush_q, rsp_flush_d;
    logic               rsp_way_q, rsp_way_d;

    logic               hit0_s, hit1_s, hit_s, sel_way_s;
    logic [1:0]         old_state_s, next_state_s;
    logic               flush_s, wr_needed_s;
    logic               addr_lsb_unused_s;

    // Byte-offset bits never participate in the lookup.
    assign addr_lsb_unused_s = ^snp_addr[1:0];

    // Way-hit detection on the RAM data returned in DECIDE; way 0 has priority.
    always_comb begin
        hit0_s      = (w0_tag_in == tag_q) && msi_is_valid(w0_state_in);
        hit1_s      = (w1_tag_in == tag_q) && msi_is_valid(w1_state_in);
        sel_way_s   = (!hit0_s) && hit1_s;
        hit_s       = (cmd_q != CMD_RSVD) && (hit0_s || hit1_s);
        old_state_s = sel_way_s ? w1_state_in : w0_state_in;
    end

    msi_snoop_decode u_decode (
        .cmd        (cmd_q),
        .old_state  (old_state_s),
        .next_state (next_state_s),
        .flush      (flush_s),
        .wr_needed  (wr_needed_s)
    );

    // Next-state and registered-output computation for the responder FSM.
    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        tag_d          = tag_q;
        index_d        = index_q;
        snp_ready_d    = snp_ready_q;
        tag_rd_en_d    = 1'b0;
        tag_rd_index_d = {INDEX_W{1'b0}};
        st_wr_en_d     = 1'b0;
        st_wr_way_d    = 1'b0;
        st_wr_index_d  = {INDEX_W{1'b0}};
        st_wr_state_d  = 2'b00;
        rsp_valid_d    = rsp_valid_q;
        rsp_hit_d      = rsp_hit_q;
        rsp_flush_d    = rsp_flush_q;
        rsp_way_d      = rsp_way_q;
        case (state_q)
            ST_IDLE: begin
                if (snp_valid && snp_ready_q) begin
                    cmd_d          = snp_cmd;
                    tag_d          = snp_addr[ADDR_W-1 -: TAG_W];
                    index_d        = snp_addr[INDEX_W+1:2];
                    snp_ready_d    = 1'b0;
                    tag_rd_en_d    = 1'b1;
                    tag_rd_index_d = snp_addr[INDEX_W+1:2];
                    state_d        = ST_LOOKUP;
                end else begin
                    snp_ready_d    = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                rsp_valid_d = 1'b1;
                rsp_hit_d   = hit_s;
                rsp_flush_d = hit_s && flush_s;
                rsp_way_d   = hit_s && sel_way_s;
                if (hit_s && wr_needed_s) begin
                    st_wr_en_d    = 1'b1;
                    st_wr_way_d   = sel_way_s;
                    st_wr_index_d = index_q;
                    st_wr_state_d = next_state_s;
                end else begin
                    st_wr_en_d    = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_hit_d   = 1'b0;
                    rsp_flush_d = 1'b0;
                    rsp_way_d   = 1'b0;
                    snp_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any snoop in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cmd_q          <= 2'b00;
            tag_q          <= {TAG_W{1'b0}};
            index_q        <= {INDEX_W{1'b0}};
            snp_ready_q    <= 1'b0;
            tag_rd_en_q    <= 1'b0;
            tag_rd_index_q <= {INDEX_W{1'b0}};
            st_wr_en_q     <= 1'b0;
            st_wr_way_q    <= 1'b0;
            st_wr_index_q  <= {INDEX_W{1'b0}};
            st_wr_state_q  <= 2'b00;
            rsp_valid_q    <= 1'b0;
            rsp_hit_q      <= 1'b0;
            rsp_flush_q    <= 1'b0;
            rsp_way_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            tag_q          <= tag_d;
            index_q        <= index_d;
            snp_ready_q    <= snp_ready_d;
            tag_rd_en_q    <= tag_rd_en_d;
            tag_rd_index_q <= tag_rd_index_d;
            st_wr_en_q     <= st_wr_en_d;
            st_wr_way_q    <= st_wr_way_d;
            st_wr_index_q  <= st_wr_index_d;
            st_wr_state_q  <= st_wr_state_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_hit_q      <= rsp_hit_d;
            rsp_flush_q    <= rsp_flush_d;
            rsp_way_q      <= rsp_way_d;
        end
    end

    assign snp_ready    = snp_ready_q;
    assign tag_rd_en    = tag_rd_en_q;
    assign tag_rd_index = tag_rd_index_q;
    assign st_wr_en     = st_wr_en_q;
    assign st_wr_way    = st_wr_way_q;
    assign st_wr_index  = st_wr_index_q;
    assign st_wr_state  = st_wr_state_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_hit      = rsp_hit_q;
    assign rsp_flush    = rsp_flush_q;
    assign rsp_way      = rsp_way_q;

endmodule
